add_group_reduce: RTL and testbench

Parametrised channel reducer for the feature-map adder stage. It sums each group of `GROUP` consecutive input channels into one output channel, giving `CH_IN/GROUP` outputs. Every input lane has its own elastic FIFO, so streams from different upstream branches can arrive skewed by up to `D` pixels and still be summed pixel-aligned. This is the generalised successor of the fixed 3:1 channel adders: channel count, group size and skew depth are parameters, and it adds optional saturation, overflow flags and a flush.

---
 rtl/add_group_reduce_if.sv | 33 +++
 rtl/add_group_reduce.sv | 148 ++++++++++++++
 tb/tb_add_group_reduce.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_group_reduce_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : add_group_reduce_if
// Purpose  : Lane push / group output bundle for the grouped channel reducer.
// Revision : 1.0
// ============================================================================
interface add_group_reduce_if #(
    parameter int CH_IN      = 96,
    parameter int GROUP      = 3,
    parameter int DATA_WIDTH = 32
);
    localparam int CH_OUT = CH_IN / GROUP;

    logic [CH_IN-1:0]             valid_in;
    logic [CH_IN*DATA_WIDTH-1:0]  pxl_in;
    logic [CH_OUT*DATA_WIDTH-1:0] pxl_out;
    logic [CH_OUT-1:0]            valid_out;
    logic [CH_OUT-1:0]            ovf_err;
    logic [CH_OUT-1:0]            sat_hit;

    modport master (
        output valid_in, pxl_in,
        input  pxl_out, valid_out, ovf_err, sat_hit
    );

    modport slave (
        input  valid_in, pxl_in,
        output pxl_out, valid_out, ovf_err, sat_hit
    );
endinterface

`default_nettype wire

// File: rtl/add_group_reduce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : add_group_reduce
// Purpose  : Sums each GROUP of skew-tolerant lane FIFOs into one output pixel.
// Revision : 1.0
// ============================================================================
module add_group_reduce #(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32,
    parameter int CH_IN      = 96,
    parameter int GROUP      = 3,
    parameter bit SAT        = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    add_group_reduce_if.slave bus
);
    localparam int CH_OUT = CH_IN / GROUP;
    localparam int PTR_W  = $clog2(D);
    localparam int CNT_W  = $clog2(D + 1);
    localparam int SUM_W  = DATA_WIDTH + $clog2(GROUP);

    logic [CH_IN-1:0]             w_lane_ready;
    logic [CH_IN-1:0]             w_lane_ovf;
    logic [CH_IN*DATA_WIDTH-1:0]  w_head;
    logic [CH_OUT-1:0]            w_grp_pop;
    logic [CH_OUT-1:0]            w_grp_ovf;
    logic [CH_OUT-1:0]            w_clip;
    logic [CH_OUT*DATA_WIDTH-1:0] w_res;

    logic [CH_OUT-1:0]            r_stg_vld;
    logic [CH_OUT-1:0]            r_vld;
    logic [CH_OUT-1:0]            r_ovf;
    logic [CH_OUT-1:0]            r_sat;
    logic [CH_OUT*DATA_WIDTH-1:0] r_pxl;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [SUM_W-1:0] group_sum(input logic [GROUP*DATA_WIDTH-1:0] ops);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < GROUP; k++) begin
            acc = acc + {{(SUM_W-DATA_WIDTH){ops[k*DATA_WIDTH+DATA_WIDTH-1]}},
                         ops[k*DATA_WIDTH +: DATA_WIDTH]};
        end
        return acc;
    endfunction

    // Returns {clipped, value}; in range when all bits above the sign agree with it.
    function automatic logic [DATA_WIDTH:0] clip(input logic [SUM_W-1:0] s);
        logic [SUM_W-DATA_WIDTH:0] top;
        top = s[SUM_W-1:DATA_WIDTH-1];
        if (SAT && !((&top) || !(|top)))
            return {1'b1, s[SUM_W-1], {(DATA_WIDTH-1){~s[SUM_W-1]}}};
        return {1'b0, s[DATA_WIDTH-1:0]};
    endfunction

    for (genvar i = 0; i < CH_IN; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [D];
        logic [PTR_W-1:0]      r_wr_ptr;
        logic [PTR_W-1:0]      r_rd_ptr;
        logic [CNT_W-1:0]      r_count;
        logic [DATA_WIDTH-1:0] r_head;
        logic                  w_pop;
        logic                  w_push;
        logic                  w_full;

        // A full FIFO still accepts a word when its group pops on the same edge.
        assign w_pop           = w_grp_pop[i / GROUP];
        assign w_full          = (r_count == CNT_W'(D));
        assign w_push          = bus.valid_in[i] && !flush && (!w_full || w_pop);
        assign w_lane_ovf[i]   = bus.valid_in[i] && !flush && w_full && !w_pop;
        assign w_lane_ready[i] = (r_count != '0);
        assign w_head[i*DATA_WIDTH +: DATA_WIDTH] = r_head;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= next_ptr(r_wr_ptr);
                if (w_pop)
                    r_rd_ptr <= next_ptr(r_rd_ptr);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_push)
                mem[r_wr_ptr] <= bus.pxl_in[i*DATA_WIDTH +: DATA_WIDTH];
            if (w_pop)
                r_head <= mem[r_rd_ptr];
        end
    end

    for (genvar j = 0; j < CH_OUT; j++) begin : g_grp
        assign w_grp_pop[j] = &w_lane_ready[j*GROUP +: GROUP];
        assign w_grp_ovf[j] = |w_lane_ovf[j*GROUP +: GROUP];
        assign {w_clip[j], w_res[j*DATA_WIDTH +: DATA_WIDTH]} =
            clip(group_sum(w_head[j*GROUP*DATA_WIDTH +: GROUP*DATA_WIDTH]));
    end

    // Stage 1 holds the popped operands, stage 2 registers the clipped sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stg_vld <= '0;
            r_vld     <= '0;
            r_ovf     <= '0;
            r_sat     <= '0;
            r_pxl     <= '0;
        end else if (flush) begin
            r_stg_vld <= '0;
            r_vld     <= '0;
            r_ovf     <= '0;
            r_sat     <= '0;
        end else begin
            r_stg_vld <= w_grp_pop;
            r_vld     <= r_stg_vld;
            r_ovf     <= r_ovf | w_grp_ovf;
            r_sat     <= r_sat | (w_clip & r_stg_vld);
            for (int j = 0; j < CH_OUT; j++) begin
                if (r_stg_vld[j])
                    r_pxl[j*DATA_WIDTH +: DATA_WIDTH] <= w_res[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.pxl_out   = r_pxl;
    assign bus.valid_out = r_vld;
    assign bus.ovf_err   = r_ovf;
    assign bus.sat_hit   = r_sat;
endmodule

`default_nettype wire

// File: tb/tb_add_group_reduce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_add_group_reduce
// Purpose  : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_add_group_reduce;
    localparam int D        = 220;
    localparam int DW       = 32;
    localparam int CH_IN    = 96;
    localparam int GROUP    = 3;
    localparam int CH_OUT   = CH_IN / GROUP;
    localparam int CH_B     = 6;
    localparam int CH_OUT_B = CH_B / GROUP;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    add_group_reduce_if #(.CH_IN(CH_IN), .GROUP(GROUP), .DATA_WIDTH(DW)) bus_a ();
    add_group_reduce_if #(.CH_IN(CH_B),  .GROUP(GROUP), .DATA_WIDTH(DW)) bus_b ();

    add_group_reduce #(.D(D), .DATA_WIDTH(DW), .CH_IN(CH_IN), .GROUP(GROUP), .SAT(1'b1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_a.slave));
    add_group_reduce #(.D(D), .DATA_WIDTH(DW), .CH_IN(CH_B), .GROUP(GROUP), .SAT(1'b0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_b.slave));

    // The wrapping instance sees the same traffic as the first two groups.
    assign bus_b.valid_in = bus_a.valid_in[CH_B-1:0];
    assign bus_b.pxl_in   = bus_a.pxl_in[CH_B*DW-1:0];

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int strobes0 = 0;
    int others   = 0;

    logic [DW-1:0]          mq [CH_IN][$];
    bit   [CH_OUT-1:0]      stg_vld = '0;
    longint                 stg_sum [CH_OUT];
    logic [CH_OUT-1:0]      exp_vld = '0;
    logic [CH_OUT-1:0]      exp_ovf = '0;
    logic [CH_OUT-1:0]      exp_sat = '0;
    logic [CH_OUT*DW-1:0]   exp_pxl_a = '0;
    logic [CH_OUT_B*DW-1:0] exp_pxl_b = '0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, idx, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH_IN; i++) mq[i].delete();
        stg_vld = '0; exp_vld = '0; exp_ovf = '0; exp_sat = '0;
        exp_pxl_a = '0; exp_pxl_b = '0;
    endtask

    // One clock edge of the specified behaviour, from pre-edge state and current inputs.
    task automatic model_update();
        bit [CH_OUT-1:0] pop;
        longint s;
        for (int j = 0; j < CH_OUT; j++) begin
            exp_vld[j] = 1'b0;
            if (!flush && stg_vld[j]) begin
                exp_vld[j] = 1'b1;
                s = stg_sum[j];
                if (s > MAXV) begin
                    exp_pxl_a[j*DW +: DW] = 32'h7FFF_FFFF; exp_sat[j] = 1'b1;
                end else if (s < MINV) begin
                    exp_pxl_a[j*DW +: DW] = 32'h8000_0000; exp_sat[j] = 1'b1;
                end else begin
                    exp_pxl_a[j*DW +: DW] = s[DW-1:0];
                end
                if (j < CH_OUT_B) exp_pxl_b[j*DW +: DW] = s[DW-1:0];
            end
        end
        if (flush) begin
            for (int i = 0; i < CH_IN; i++) mq[i].delete();
            stg_vld = '0; exp_ovf = '0; exp_sat = '0;
        end else begin
            for (int j = 0; j < CH_OUT; j++) begin
                pop[j] = 1'b1;
                for (int k = 0; k < GROUP; k++)
                    if (mq[j*GROUP+k].size() == 0) pop[j] = 1'b0;
            end
            for (int j = 0; j < CH_OUT; j++) begin
                stg_vld[j] = pop[j];
                if (pop[j]) begin
                    s = 0;
                    for (int k = 0; k < GROUP; k++)
                        s += longint'($signed(mq[j*GROUP+k].pop_front()));
                    stg_sum[j] = s;
                end
            end
            for (int i = 0; i < CH_IN; i++) begin
                if (bus_a.valid_in[i]) begin
                    if (mq[i].size() < D) mq[i].push_back(bus_a.pxl_in[i*DW +: DW]);
                    else exp_ovf[i/GROUP] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        chk("valid_out_a", 0, 64'(bus_a.valid_out), 64'(exp_vld));
        chk("ovf_err_a",   0, 64'(bus_a.ovf_err),   64'(exp_ovf));
        chk("sat_hit_a",   0, 64'(bus_a.sat_hit),   64'(exp_sat));
        for (int j = 0; j < CH_OUT; j++)
            chk("pxl_out_a", j, 64'(bus_a.pxl_out[j*DW +: DW]), 64'(exp_pxl_a[j*DW +: DW]));
        chk("valid_out_b", 0, 64'(bus_b.valid_out), 64'(exp_vld[CH_OUT_B-1:0]));
        chk("ovf_err_b",   0, 64'(bus_b.ovf_err),   64'(exp_ovf[CH_OUT_B-1:0]));
        chk("sat_hit_b",   0, 64'(bus_b.sat_hit),   64'd0);
        for (int j = 0; j < CH_OUT_B; j++)
            chk("pxl_out_b", j, 64'(bus_b.pxl_out[j*DW +: DW]), 64'(exp_pxl_b[j*DW +: DW]));
    end

    task automatic idle_inputs();
        bus_a.valid_in = '0;
        bus_a.pxl_in   = '0;
        flush          = 1'b0;
    endtask

    task automatic drive(input int lane, input logic [DW-1:0] v);
        bus_a.valid_in[lane]       = 1'b1;
        bus_a.pxl_in[lane*DW +: DW] = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) model_update();
        @(negedge clk);
        if (bus_a.valid_out[0]) strobes0++;
        if (|bus_a.valid_out[CH_OUT-1:1]) others++;
        idle_inputs();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        model_reset();
        repeat (3) cyc();
        chk("reset_valid", 0, 64'(bus_a.valid_out), 64'd0);
        chk("reset_pxl",   0, 64'(|bus_a.pxl_out),  64'd0);
        reset = 1'b0;

        // Aligned stream: 1+2+3 for ten cycles
        strobes0 = 0; others = 0;
        for (int k = 0; k < 10; k++) begin
            drive(0, 1); drive(1, 2); drive(2, 3);
            cyc();
            if (k == 1) chk("aligned_lat_early", 0, 64'(bus_a.valid_out[0]), 64'd0);
            if (k == 2) chk("aligned_lat_first", 0, 64'(bus_a.valid_out[0]), 64'd1);
        end
        repeat (4) cyc();
        chk("aligned_count",  0, 64'(strobes0), 64'd10);
        chk("aligned_others", 0, 64'(others),   64'd0);
        chk("aligned_value",  0, 64'(bus_a.pxl_out[DW-1:0]), 64'd6);

        // Skewed lanes
        strobes0 = 0;
        for (int c = 0; c < 160; c++) begin
            if (c < 80)             drive(0, DW'(c));
            if (c >= 50 && c < 130) drive(1, DW'(100 + c - 50));
            if (c >= 80)            drive(2, DW'(1000 + c - 80));
            cyc();
            if (c == 81) chk("skew_early", 0, 64'(bus_a.valid_out[0]), 64'd0);
            if (c == 82) begin
                chk("skew_first_vld", 0, 64'(bus_a.valid_out[0]), 64'd1);
                chk("skew_first_val", 0, 64'(bus_a.pxl_out[DW-1:0]), 64'd1100);
            end
        end
        repeat (4) cyc();
        chk("skew_count", 0, 64'(strobes0), 64'd80);
        chk("skew_ovf",   0, 64'(bus_a.ovf_err), 64'd0);

        // Overflow of lane 0
        do_flush();
        strobes0 = 0;
        for (int k = 0; k < 221; k++) begin
            drive(0, DW'(k));
            cyc();
            if (k == 219) chk("ovf_before", 0, 64'(bus_a.ovf_err), 64'd0);
        end
        chk("ovf_set",    0, 64'(bus_a.ovf_err[0]), 64'd1);
        chk("ovf_others", 0, 64'(bus_a.ovf_err[CH_OUT-1:1]), 64'd0);
        for (int k = 0; k < 220; k++) begin
            drive(1, DW'(5000 + k)); drive(2, 7);
            cyc();
        end
        repeat (4) cyc();
        chk("ovf_drain_count", 0, 64'(strobes0), 64'd220);
        chk("ovf_drain_last",  0, 64'(bus_a.pxl_out[DW-1:0]), 64'd5445);

        // Full FIFO pushed on its pop cycle
        do_flush();
        for (int k = 0; k < 220; k++) begin
            drive(0, DW'(k));
            cyc();
        end
        drive(1, 10); drive(2, 20);
        cyc();
        drive(0, 999);
        cyc();
        chk("full_pushpop_ovf", 0, 64'(bus_a.ovf_err[0]), 64'd0);
        drive(0, 555);
        cyc();
        chk("full_still_full", 0, 64'(bus_a.ovf_err[0]), 64'd1);

        // Saturation versus wrap
        do_flush();
        drive(0, 32'h7FFF_FFFF); drive(1, 32'h7FFF_FFFF); drive(2, 1);
        cyc();
        repeat (3) cyc();
        chk("sat_pos_a",   0, 64'(bus_a.pxl_out[DW-1:0]), 64'h7FFF_FFFF);
        chk("sat_pos_hit", 0, 64'(bus_a.sat_hit[0]), 64'd1);
        chk("wrap_pos_b",  0, 64'(bus_b.pxl_out[DW-1:0]), 64'hFFFF_FFFF);
        chk("wrap_hit_b",  0, 64'(bus_b.sat_hit), 64'd0);
        drive(0, 32'h8000_0000); drive(1, 32'h8000_0000); drive(2, 32'h8000_0000);
        cyc();
        repeat (3) cyc();
        chk("sat_neg_a",  0, 64'(bus_a.pxl_out[DW-1:0]), 64'h8000_0000);
        chk("wrap_neg_b", 0, 64'(bus_b.pxl_out[DW-1:0]), 64'h8000_0000);

        // Flush with partially filled FIFOs; lane 2 push in the flush cycle is dropped
        drive(0, 11); drive(1, 12);
        cyc();
        drive(0, 13);
        cyc();
        flush = 1'b1; drive(2, 50);
        cyc();
        chk("flush_sat", 0, 64'(bus_a.sat_hit), 64'd0);
        drive(0, 7); drive(1, 8); drive(2, 9);
        cyc();
        cyc();
        cyc();
        chk("flush_next_vld", 0, 64'(bus_a.valid_out[0]), 64'd1);
        chk("flush_next_val", 0, 64'(bus_a.pxl_out[DW-1:0]), 64'd24);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) begin
            for (int l = 0; l < 12; l++) drive(l, DW'($urandom));
            cyc();
        end
        for (int l = 0; l < 12; l++) drive(l, DW'($urandom));
        @(posedge clk);
        model_update();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 0, 64'(bus_a.valid_out), 64'd0);
        chk("arst_pxl",   0, 64'(|bus_a.pxl_out),  64'd0);
        chk("arst_ovf",   0, 64'(bus_a.ovf_err),   64'd0);
        chk("arst_sat",   0, 64'(bus_a.sat_hit),   64'd0);
        @(negedge clk);
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b0;
        drive(15, 4); drive(16, 5); drive(17, 6);
        cyc();
        cyc();
        chk("arst_resume_early", 0, 64'(bus_a.valid_out), 64'd0);
        cyc();
        chk("arst_resume_vld", 0, 64'(bus_a.valid_out), 64'(32'h0000_0020));
        chk("arst_resume_val", 0, 64'(bus_a.pxl_out[5*DW +: DW]), 64'd15);

        // Random traffic on all lanes, extremes mixed in, rare flushes
        for (int c = 0; c < 2000; c++) begin
            for (int l = 0; l < CH_IN; l++) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 7))
                        0:       drive(l, 32'h7FFF_FFFF);
                        1:       drive(l, 32'h8000_0000);
                        default: drive(l, DW'($urandom));
                    endcase
                end
            end
            if ($urandom_range(0, 199) == 0) flush = 1'b1;
            cyc();
        end
        repeat (5) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
